// File: rtl/encoded_memory_ctrl_pkg.sv
// Shared definitions for the encoded scratch store.
//   op_t    : request opcode carried on the 'op' port
//   state_t : controller FSM state, also visible on the state_dbg port
package encoded_memory_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_WRITE     = 2'b00,
        OP_READ_DIFF = 2'b01,
        OP_READ_DEC  = 2'b10,
        OP_CLEAR     = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DECODE = 2'b01,
        ST_CLEAR  = 2'b10
    } state_t;

endpackage

// File: rtl/encode_mask_rom.sv
// Per-address mask generator for the encoded store.
//   addr     in  AW     entry index
//   mask     out WIDTH  (addr * MASK_STEP) mod 2^WIDTH
//   in_range out 1      addr < DEPTH (only ever low for non-power-of-2 DEPTH)
// Purely combinational; the "ROM" is a multiply by a constant step.
module encode_mask_rom #(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 8,
    parameter int                AW        = $clog2(DEPTH),
    parameter logic [WIDTH-1:0]  MASK_STEP = WIDTH'(8'h55)
) (
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] mask,
    output logic             in_range
);

    // One extra bit so DEPTH itself is representable when DEPTH == 2**AW.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    // Truncation to WIDTH bits is the mod 2^WIDTH of the mask definition.
    assign mask     = MASK_STEP * WIDTH'(addr);
    assign in_range = ({1'b0, addr} < DEPTH_W);

endmodule

// File: rtl/encoded_memory_ctrl.sv
// Encoded scratch memory: each entry holds |data - mask(addr)| plus a sign
// bit, so reads can return either the raw difference or the decoded word.
//   CLK, RST    clock (rising edge), asynchronous active-high reset
//   req_valid   request present
//   req_ready   block accepts a request this cycle (state == IDLE)
//   op          00 write, 01 read-diff, 10 read-decoded, 11 clear
//   addr        entry index
//   dataIn      write data
//   dataOut     registered read result, held while out_valid is low
//   sign_out    registered stored sign of the read entry
//   out_valid   one-cycle pulse marking a new read result
//   busy        high while a clear sweep runs
//   state_dbg   current FSM state, for observation only
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_ready depends only on state, never on req_valid. A request presented
// while req_ready is low is dropped, not queued; the requester must hold it
// until it sees ready.
module encoded_memory_ctrl
    import encoded_memory_ctrl_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 8,
    parameter int                AW        = $clog2(DEPTH),
    parameter logic [WIDTH-1:0]  MASK_STEP = WIDTH'(8'h55)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic             sign_out,
    output logic             out_valid,
    output logic             busy,
    output state_t           state_dbg
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    dec_addr;
    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] mask;
    logic             in_range;

    // Storage is deliberately not reset; valid_q masks stale contents.
    logic [WIDTH-1:0] diff_mem [DEPTH];
    logic             sign_mem [DEPTH];
    logic [DEPTH-1:0] valid_q;

    logic             accept;
    logic             do_write;
    logic [WIDTH-1:0] wr_diff;
    logic             wr_sign;
    logic             rd_hit;
    logic [WIDTH-1:0] rd_diff;
    logic             rd_sign;
    logic [WIDTH-1:0] dec_value;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign state_dbg = state;

    // One mask ROM serves both phases: in DECODE it looks up the latched
    // address, otherwise the live request address.
    assign rom_addr = (state == ST_DECODE) ? dec_addr : addr;

    encode_mask_rom #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .MASK_STEP (MASK_STEP)
    ) u_mask_rom (
        .addr     (rom_addr),
        .mask     (mask),
        .in_range (in_range)
    );

    assign wr_sign  = (dataIn < mask);
    assign wr_diff  = wr_sign ? (mask - dataIn) : (dataIn - mask);
    assign do_write = accept && (op == OP_WRITE) && in_range;

    // Invalid or out-of-range entries read as zero in both modes; the decoded
    // path is forced to zero too, otherwise it would return the bare mask.
    assign rd_hit    = in_range && valid_q[rom_addr];
    assign rd_diff   = rd_hit ? diff_mem[rom_addr] : '0;
    assign rd_sign   = rd_hit ? sign_mem[rom_addr] : 1'b0;
    assign dec_value = rd_hit ? (rd_sign ? (mask - rd_diff) : (mask + rd_diff)) : '0;

    always_ff @(posedge CLK) begin
        if (do_write) begin
            diff_mem[addr] <= wr_diff;
            sign_mem[addr] <= wr_sign;
        end else if (state == ST_CLEAR) begin
            diff_mem[ptr] <= '0;
            sign_mem[ptr] <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            dec_addr  <= '0;
            dataOut   <= '0;
            sign_out  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            valid_q   <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_t'(op))
                            OP_WRITE: begin
                                if (in_range) valid_q[addr] <= 1'b1;
                            end
                            OP_READ_DIFF: begin
                                dataOut   <= rd_diff;
                                sign_out  <= rd_sign;
                                out_valid <= 1'b1;
                            end
                            OP_READ_DEC: begin
                                dec_addr <= addr;
                                state    <= ST_DECODE;
                            end
                            OP_CLEAR: begin
                                ptr   <= '0;
                                busy  <= 1'b1;
                                state <= ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DECODE: begin
                    dataOut   <= dec_value;
                    sign_out  <= rd_sign;
                    out_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_CLEAR: begin
                    valid_q[ptr] <= 1'b0;
                    if (ptr == LAST) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoded_memory_ctrl.sv
module tb_encoded_memory_ctrl;
  import encoded_memory_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  // instance a: DEPTH 8, instance b: DEPTH 6
  logic       a_rv, b_rv;
  logic [1:0] a_op, b_op;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_din, b_din;
  logic       a_rdy, b_rdy, a_sgn, b_sgn, a_ov, b_ov, a_busy, b_busy;
  logic [7:0] a_dout, b_dout;
  state_t     a_st, b_st;

  encoded_memory_ctrl dut_a (
    .CLK(CLK), .RST(RST), .req_valid(a_rv), .req_ready(a_rdy), .op(a_op),
    .addr(a_addr), .dataIn(a_din), .dataOut(a_dout), .sign_out(a_sgn),
    .out_valid(a_ov), .busy(a_busy), .state_dbg(a_st)
  );

  encoded_memory_ctrl #(.DEPTH(6)) dut_b (
    .CLK(CLK), .RST(RST), .req_valid(b_rv), .req_ready(b_rdy), .op(b_op),
    .addr(b_addr), .dataIn(b_din), .dataOut(b_dout), .sign_out(b_sgn),
    .out_valid(b_ov), .busy(b_busy), .state_dbg(b_st)
  );

  // ---------------- reference model ----------------
  // Keeps the original written word per entry; expected reads are derived
  // from the mask/difference rules with plain integer arithmetic.
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_orig [2][8];
  bit   m_vld  [2][8];
  int   depth_of [2] = '{8, 6};
  logic [8:0] exp_q [$];   // {sign, data}
  logic [8:0] last_e;

  function automatic int mask_of(int i);
    return (i * 'h55) % 256;
  endfunction

  function automatic logic [8:0] model_read(int sel, int ad, bit dec);
    int m, o;
    if (ad >= depth_of[sel] || !m_vld[sel][ad]) return 9'h000;
    m = mask_of(ad);
    o = m_orig[sel][ad];
    if (dec) return {(o < m) ? 1'b1 : 1'b0, 8'(o)};
    return {(o < m) ? 1'b1 : 1'b0, 8'((o >= m) ? (o - m) : (m - o))};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int sel, input logic v, input logic [1:0] op,
                       input logic [2:0] ad, input logic [7:0] d);
    if (sel == 0) begin a_rv = v; a_op = op; a_addr = ad; a_din = d; end
    else          begin b_rv = v; b_op = op; b_addr = ad; b_din = d; end
  endtask

  task automatic sample(input int sel, output logic rdy, output logic bsy,
                        output logic ov, output logic sg, output logic [7:0] q);
    if (sel == 0) begin rdy = a_rdy; bsy = a_busy; ov = a_ov; sg = a_sgn; q = a_dout; end
    else          begin rdy = b_rdy; bsy = b_busy; ov = b_ov; sg = b_sgn; q = b_dout; end
  endtask

  // Presents one request, waits (bounded) for ready, returns #1 after the
  // accepting edge with req_valid dropped.
  task automatic send(input int sel, input logic [1:0] op, input logic [2:0] ad,
                      input logic [7:0] d);
    logic rdy, bsy, ov, sg;
    logic [7:0] q;
    int guard = 0;
    sample(sel, rdy, bsy, ov, sg, q);
    while (!rdy && guard < 50) begin
      @(posedge CLK); #1;
      guard++;
      sample(sel, rdy, bsy, ov, sg, q);
    end
    if (!rdy) check("ready_timeout", 32'(rdy), 32'd1);
    drive(sel, 1'b1, op, ad, d);
    @(posedge CLK); #1;
    drive(sel, 1'b0, op, ad, d);
  endtask

  task automatic wr(input int sel, input int ad, input int d);
    send(sel, OP_WRITE, 3'(ad), 8'(d));
    if (ad < depth_of[sel]) begin
      m_orig[sel][ad] = d;
      m_vld[sel][ad]  = 1'b1;
    end
  endtask

  task automatic rd(input int sel, input int ad, input bit dec);
    logic rdy, bsy, ov, sg;
    logic [7:0] q;
    logic [8:0] e;
    exp_q.push_back(model_read(sel, ad, dec));
    send(sel, dec ? OP_READ_DEC : OP_READ_DIFF, 3'(ad), 8'h00);
    sample(sel, rdy, bsy, ov, sg, q);
    if (dec) begin
      check("dec_ready_low", 32'(rdy), 32'd0);
      check("dec_no_early_valid", 32'(ov), 32'd0);
      @(posedge CLK); #1;
      sample(sel, rdy, bsy, ov, sg, q);
      check("dec_ready_back", 32'(rdy), 32'd1);
    end
    check("out_valid", 32'(ov), 32'd1);
    e = exp_q.pop_front();
    last_e = e;
    check(dec ? "dec_data" : "diff_data", 32'(q), 32'(e[7:0]));
    check(dec ? "dec_sign" : "diff_sign", 32'(sg), 32'(e[8]));
  endtask

  // Issues a clear and counts busy cycles; optionally tries a write mid-sweep.
  task automatic clr(input int sel, input bit inject);
    logic rdy, bsy, ov, sg;
    logic [7:0] q;
    int cyc = 0;
    send(sel, OP_CLEAR, 3'd0, 8'h00);
    sample(sel, rdy, bsy, ov, sg, q);
    while (bsy && cyc < 40) begin
      if (rdy) check("clear_ready_low", 32'(rdy), 32'd0);
      if (inject && cyc == 2) drive(sel, 1'b1, OP_WRITE, 3'd4, 8'h77);
      @(posedge CLK); #1;
      drive(sel, 1'b0, OP_WRITE, 3'd4, 8'h77);
      cyc++;
      sample(sel, rdy, bsy, ov, sg, q);
    end
    check("clear_cycles", 32'(cyc), 32'(depth_of[sel]));
    check("clear_ready_after", 32'(rdy), 32'd1);
    for (int i = 0; i < 8; i++) m_vld[sel][i] = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic rdy, bsy, ov, sg;
    logic [7:0] q;
    int r, ad;

    RST = 1'b1;
    drive(0, 1'b0, 2'b00, 3'd0, 8'h00);
    drive(1, 1'b0, 2'b00, 3'd0, 8'h00);
    repeat (3) @(posedge CLK);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s, rdy, bsy, ov, sg, q);
      check("rst_dataOut", 32'(q), 32'd0);
      check("rst_sign", 32'(sg), 32'd0);
      check("rst_out_valid", 32'(ov), 32'd0);
      check("rst_busy", 32'(bsy), 32'd0);
      check("rst_ready", 32'(rdy), 32'd1);
    end
    RST = 1'b0;

    // empty entry read, pulse width and hold
    rd(0, 5, 0);
    sample(0, rdy, bsy, ov, sg, q);
    check("idle_ready", 32'(rdy), 32'd1);
    check("idle_busy", 32'(bsy), 32'd0);

    wr(0, 1, 'h20);
    rd(0, 1, 0);
    @(posedge CLK); #1;
    sample(0, rdy, bsy, ov, sg, q);
    check("pulse_low", 32'(ov), 32'd0);
    check("hold_data", 32'(q), 32'(last_e[7:0]));
    check("hold_sign", 32'(sg), 32'(last_e[8]));
    rd(0, 1, 1);

    wr(0, 2, 'hFF);
    rd(0, 2, 0);
    rd(0, 2, 1);
    wr(0, 3, 'h00);
    rd(0, 3, 0);   // back-to-back with the write

    // clear with an ignored write mid-sweep
    clr(0, 1'b1);
    rd(0, 1, 1);
    rd(0, 2, 1);
    rd(0, 4, 1);
    rd(0, 4, 0);

    // reset in the middle of a clear sweep
    wr(0, 6, 'h9C);
    wr(0, 0, 'h41);
    rd(0, 6, 0);
    send(0, OP_CLEAR, 3'd0, 8'h00);
    repeat (3) begin @(posedge CLK); #1; end
    #2 RST = 1'b1;
    #1;
    sample(0, rdy, bsy, ov, sg, q);
    check("abort_dataOut", 32'(q), 32'd0);
    check("abort_sign", 32'(sg), 32'd0);
    check("abort_busy", 32'(bsy), 32'd0);
    check("abort_ready", 32'(rdy), 32'd1);
    check("abort_state", 32'(a_st), 32'(ST_IDLE));
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) m_vld[s][i] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(0, i, 0);
      rd(0, i, 1);
    end

    // reset during a decoded read
    wr(0, 7, 'h3C);
    send(0, OP_READ_DEC, 3'd7, 8'h00);
    #2 RST = 1'b1;
    #1;
    check("abort_dec_ready", 32'(a_rdy), 32'd1);
    check("abort_dec_valid", 32'(a_ov), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 8; i++) m_vld[0][i] = 1'b0;
    rd(0, 7, 1);

    // DEPTH 6 instance: out-of-range addresses
    wr(1, 7, 'h12);
    rd(1, 7, 0);
    rd(1, 7, 1);
    wr(1, 5, 'h00);
    rd(1, 5, 0);
    rd(1, 5, 1);
    clr(1, 1'b0);
    rd(1, 5, 0);

    // randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 150; k++) begin
        r  = $urandom_range(0, 99);
        ad = $urandom_range(0, 7);
        if (r < 40)      wr(s, ad, $urandom_range(0, 255));
        else if (r < 68) rd(s, ad, 0);
        else if (r < 94) rd(s, ad, 1);
        else if (r < 97) begin @(posedge CLK); #1; end
        else             clr(s, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
